// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage core.
// Produces stall, bubble, flush and freeze controls from load-use hazards,
// taken branches and data-memory wait states. Tracks long memory waits with
// a timeout FSM and keeps saturating stall/flush performance counters.
module hazard_stall_controller #(
    parameter int REGISTER_FILE_ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH                   = 32,
    parameter int WAIT_TIMEOUT                = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ifid_rs1,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ifid_rs2,
    input  logic                                   ifid_uses_rs1,
    input  logic                                   ifid_uses_rs2,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] idex_rd,
    input  logic                                   idex_ctrl_mem_r,
    input  logic                                   ex_branch_taken,
    input  logic                                   dmem_req,
    input  logic                                   dmem_ready,
    output logic                                   pc_write_en,
    output logic                                   ifid_write_en,
    output logic                                   ifid_flush,
    output logic                                   idex_bubble,
    output logic                                   pipe_freeze,
    output logic                                   mem_timeout,
    output logic [CNT_WIDTH-1:0]                   stall_cycles,
    output logic [CNT_WIDTH-1:0]                   flush_count
);

    // Wide enough to hold WAIT_TIMEOUT-1 with headroom.
    localparam int WCW = $clog2(WAIT_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [WCW-1:0]         wait_cnt_reg, wait_cnt_next;
    logic                   mem_timeout_reg, mem_timeout_next;
    logic [CNT_WIDTH-1:0]   stall_cycles_reg;
    logic [CNT_WIDTH-1:0]   flush_count_reg;

    logic mem_wait;
    logic load_use;
    logic freeze_act;
    logic branch_act;
    logic rs1_hit;
    logic rs2_hit;

    assign mem_wait = dmem_req & ~dmem_ready;
    assign rs1_hit  = ifid_uses_rs1 & (idex_rd == ifid_rs1);
    assign rs2_hit  = ifid_uses_rs2 & (idex_rd == ifid_rs2);
    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = idex_ctrl_mem_r & (idex_rd != '0) & (rs1_hit | rs2_hit);

    // Freeze outranks everything: EX and ID hold, so a masked branch or
    // hazard simply re-presents once the pipeline is released.
    assign freeze_act = (state_reg == ST_ERR) | mem_wait;
    assign branch_act = ~freeze_act & ex_branch_taken;

    // Priority-encoded pipeline controls; forced to free-run while in reset.
    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        pipe_freeze   = 1'b0;
        if (rst_n) begin
            if (freeze_act) begin
                pipe_freeze   = 1'b1;
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
            end else if (ex_branch_taken) begin
                // The ID instruction is squashed, so any load-use on it is moot.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_bubble   = 1'b1;
            end
        end
    end

    // Memory-wait timeout FSM next-state logic.
    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_timeout_next = mem_timeout_reg;
        case (state_reg)
            ST_RUN: begin
                if (mem_wait) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = WCW'(1);
                end
            end
            ST_WAIT: begin
                if (!mem_wait) begin
                    // The ready cycle itself is not frozen.
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WCW'(WAIT_TIMEOUT - 1)) begin
                    state_next       = ST_ERR;
                    mem_timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WCW'(1);
                end
            end
            ST_ERR: begin
                // Absorbing until reset.
                mem_timeout_next = 1'b1;
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_RUN;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
        end
    end

    // Saturating performance counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (!pc_write_en && (stall_cycles_reg != '1))
                stall_cycles_reg <= stall_cycles_reg + CNT_WIDTH'(1);
            if (branch_act && (flush_count_reg != '1))
                flush_count_reg <= flush_count_reg + CNT_WIDTH'(1);
        end
    end

    assign mem_timeout  = mem_timeout_reg;
    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;

endmodule
